ysyx_22040088_lsu_ctrl: RTL
===========================

Name: ysyx_22040088_lsu_ctrl

Overview:
Load/store sequencer between decode/execute and the 64-bit data memory bus. Accepts one memory op at a time, carrying the decoder's mem_wen, mem_mask and sel_memdata plus the ALU address and store data. It checks alignment, produces the aligned bus address, byte strobes and shifted write data, then runs the bus handshake. For loads it extracts and sign- or zero-extends the returned data. The pipeline stalls on busy.

Parameters:
ADDR_W, 32, address width of req_addr and bus_req_addr
XLEN, 64, data width; the design supports only 64

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  memory op present (decoder mem_ena)
req_ready  out  1  op accepted this cycle
req_wen  in  1  1 = store, 0 = load
req_mask  in  4  one-hot size: 0001 dword, 0010 word, 0100 half, 1000 byte
req_sel_memdata  in  2  bit0 = sign-extend load, bit1 = zero-extend load
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, right-aligned
req_rd  in  5  load destination register
busy  out  1  op in flight (state != IDLE)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
resp_rd  out  5  captured req_rd
resp_err  out  1  misaligned access or illegal mask
bus_req_valid  out  1  bus request
bus_req_ready  in  1  bus accepts request
bus_req_wen  out  1  write request
bus_req_addr  out  ADDR_W  {req_addr[ADDR_W-1:3], 3'b000}
bus_req_wstrb  out  8  byte strobes (0 for reads)
bus_req_wdata  out  XLEN  lane-shifted store data
bus_resp_valid  in  1  read data / write ack
bus_resp_rdata  in  XLEN  read data, full doubleword

Behaviour:
- Reset (async, rst_n=0): state IDLE; every registered output and all captured fields are 0. req_ready is 0 while rst_n=0. Reset mid-transaction abandons the op with no resp_valid. The bus side must also be reset.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1, capture wen, mask, sel_memdata, addr, wdata and rd.
  - Go to REQ if the access is legal. Otherwise go to RESP with err=1 and issue no bus transaction.
- Legality:
  - mask must be one-hot.
  - dword requires addr[2:0]=0, word requires addr[1:0]=0, half requires addr[0]=0, byte is always legal.
- REQ:
  - bus_req_valid=1; addr, wen, wstrb and wdata are held stable.
  - Leave for WAIT on bus_req_ready=1.
- WAIT:
  - Leave for RESP on bus_resp_valid=1, capturing the processed rdata.
  - bus_resp_valid in any other state is ignored.
  - No timeout.
- RESP:
  - resp_valid=1 for exactly one cycle; there is no backpressure.
  - Return to IDLE.
  - A new req is not accepted in this cycle (req_ready=0).
- Minimum latency with a zero-wait bus: accept at cycle 0, REQ cycle 1, WAIT cycle 2 (response at 2), resp_valid at cycle 3. Error path: resp_valid at cycle 1.
- Lane offset: off = addr[2:0].
  - wstrb: byte 8'h01<<off, half 8'h03<<off, word 8'h0F<<off, dword 8'hFF; reads 0.
  - wdata: req_wdata << (off*8); bytes above the access size are don't-care but are driven deterministically by the shift.
- Load extract: d = bus_resp_rdata >> (off*8), truncated to the access size.
  - If sel_memdata[1]=1, zero-extend; otherwise sign-extend.
  - dword is unchanged.
  - sel_memdata=00 on a load is treated as sign-extend.
- Stores: complete on bus_resp_valid (write ack) with resp_rdata=0.
- resp_rdata, resp_rd and resp_err are held until the next RESP. resp_err=1 forces resp_rdata=0.
- req_valid while busy is ignored, since req_ready=0.

Test Plan:
- lb addr=0x8000_0003, mask=1000, sel=01, bus rdata=0x0000_0000_8000_0000 -> bus_req_addr=0x8000_0000, wstrb=0, resp_rdata=0xFFFF_FFFF_FFFF_FF80, resp_valid exactly at cycle 3.
- lhu addr=0x8000_0006, mask=0100, sel=10, rdata=0xBEEF_0000_0000_0000 -> resp_rdata=0x0000_0000_0000_BEEF.
- sw addr=0x8000_0004, wdata=0x1234_5678, bus_req_ready low for 3 cycles -> REQ held stable 3 cycles, wstrb=8'hF0, wdata[63:32]=0x1234_5678, resp_valid after ack, resp_rdata=0.
- ld addr=0x8000_0004 (misaligned) -> no bus_req_valid, resp_valid at cycle 1, resp_err=1, resp_rdata=0.
- rst_n pulled low during WAIT -> all outputs 0 immediately; no resp_valid afterwards; next lw completes normally.
- Back-to-back loads with req_valid held high -> second accepted only in the cycle after RESP; busy high throughout the first op.

Source files
------------

// File: rtl/ysyx_22040088_lsu_ctrl.sv
// Load/store sequencer: checks alignment, lane-shifts stores, runs the 64-bit
// data-bus handshake and extends load data returned by the bus.
module ysyx_22040088_lsu_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [3:0]        req_mask,
  input  logic [1:0]        req_sel_memdata,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              busy,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_wen,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [7:0]        bus_req_wstrb,
  output logic [XLEN-1:0]   bus_req_wdata,
  input  logic              bus_resp_valid,
  input  logic [XLEN-1:0]   bus_resp_rdata
);

  localparam int unsigned EXT_W = XLEN - 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]      state;
  logic [1:0]      state_n;
  logic            accept;
  logic            legal;
  logic [7:0]      strb_n;
  logic [XLEN-1:0] wdata_n;
  logic [3:0]      mask_q;
  logic [1:0]      sel_q;
  logic [2:0]      off_q;
  logic [4:0]      rd_q;
  logic            zext;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;

  assign accept = req_valid & req_ready;

  // Size/alignment legality of the incoming op; non-one-hot masks are illegal.
  always_comb begin
    legal = 1'b0;
    case (req_mask)
      4'b0001: legal = (req_addr[2:0] == 3'b000);
      4'b0010: legal = (req_addr[1:0] == 2'b00);
      4'b0100: legal = ~req_addr[0];
      4'b1000: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    strb_n = 8'h00;
    case (req_mask)
      4'b0001: strb_n = 8'hFF;
      4'b0010: strb_n = 8'h0F << req_addr[2:0];
      4'b0100: strb_n = 8'h03 << req_addr[2:0];
      4'b1000: strb_n = 8'h01 << req_addr[2:0];
      default: strb_n = 8'h00;
    endcase
    if (!req_wen) strb_n = 8'h00;
  end

  assign wdata_n = req_wdata << {req_addr[2:0], 3'b000};

  // Load extraction: bring the addressed lane down, then size and extend it.
  assign shifted = bus_resp_rdata >> {off_q, 3'b000};

  always_comb begin
    zext = 1'b0;
    case (sel_q)
      2'b10, 2'b11: zext = 1'b1;
      default:      zext = 1'b0;
    endcase
  end

  always_comb begin
    load_data = shifted;
    case (mask_q)
      4'b0010: load_data = zext ? {{EXT_W{1'b0}}, shifted[31:0]}
                                : {{EXT_W{shifted[31]}}, shifted[31:0]};
      4'b0100: load_data = zext ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      4'b1000: load_data = zext ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = legal ? S_REQ : S_RESP;
      S_REQ:   if (bus_req_ready) state_n = S_WAIT;
      S_WAIT:  if (bus_resp_valid) state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready     <= 1'b0;
      busy          <= 1'b0;
      bus_req_valid <= 1'b0;
      resp_valid    <= 1'b0;
    end else begin
      req_ready     <= (state_n == S_IDLE);
      busy          <= (state_n != S_IDLE);
      bus_req_valid <= (state_n == S_REQ);
      resp_valid    <= (state_n == S_RESP);
    end
  end

  // Op capture and bus payload; held stable for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q        <= 4'h0;
      sel_q         <= 2'b00;
      off_q         <= 3'b000;
      rd_q          <= 5'd0;
      bus_req_wen   <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wstrb <= 8'h00;
      bus_req_wdata <= '0;
    end else if (accept) begin
      mask_q        <= req_mask;
      sel_q         <= req_sel_memdata;
      off_q         <= req_addr[2:0];
      rd_q          <= req_rd;
      bus_req_wen   <= req_wen;
      bus_req_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
      bus_req_wstrb <= strb_n;
      bus_req_wdata <= wdata_n;
    end
  end

  // Response fields change only on entry to RESP and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_rd    <= 5'd0;
      resp_err   <= 1'b0;
    end else if (state == S_IDLE && accept && !legal) begin
      resp_rdata <= '0;
      resp_rd    <= req_rd;
      resp_err   <= 1'b1;
    end else if (state == S_WAIT && bus_resp_valid) begin
      resp_rdata <= bus_req_wen ? '0 : load_data;
      resp_rd    <= rd_q;
      resp_err   <= 1'b0;
    end
  end

endmodule
